// File: rtl/fcpu_pkg.sv
// Shared definitions for the fcpu fetch front end: opcodes, queue entry layout
// and the fixed AXI read-address attributes.
package fcpu_pkg;

    localparam int CRAM_ADDR_W = 16;
    localparam int DATA_W      = 32;

    localparam logic [5:0] I_JMP  = 6'h02;
    localparam logic [5:0] I_BLE  = 6'h10;
    localparam logic [5:0] I_BLEI = 6'h11;
    localparam logic [5:0] I_BLT  = 6'h12;
    localparam logic [5:0] I_BLTF = 6'h13;
    localparam logic [5:0] I_BLTI = 6'h14;
    localparam logic [5:0] I_BEQ  = 6'h15;
    localparam logic [5:0] I_BEQF = 6'h16;
    localparam logic [5:0] I_BEQI = 6'h17;

    localparam logic [3:0] AXI_ARID    = 4'd0;
    localparam logic [7:0] AXI_ARLEN   = 8'd0;
    localparam logic [2:0] AXI_ARSIZE  = 3'd2;
    localparam logic [1:0] AXI_ARBURST = 2'd1;
    localparam logic       AXI_ARLOCK  = 1'b0;
    localparam logic [3:0] AXI_ARCACHE = 4'd0;
    localparam logic [2:0] AXI_ARPROT  = 3'd0;
    localparam logic [3:0] AXI_ARQOS   = 4'd0;

    typedef struct packed {
        logic [31:0]       pc;
        logic              take_flag;
        logic              is_branch;
        logic              err;
        logic [DATA_W-1:0] inst;
    } fetch_entry_t;

    function automatic logic is_branch_op(input logic [5:0] op);
        case (op)
            I_BLE, I_BLEI, I_BLT, I_BLTF,
            I_BLTI, I_BEQ, I_BEQF, I_BEQI: is_branch_op = 1'b1;
            default:                       is_branch_op = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with a whole-queue flush; used for the instruction queue
// and for the in-order PC tags of outstanding reads.
module fetch_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic [CNT_W-1:0] count
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(DEPTH - 1)) begin
            return '0;
        end else begin
            return p + PTR_W'(1);
        end
    endfunction

    // Pointer, occupancy and storage update
    always_ff @(posedge clk) begin
        if (!nrst || flush) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push) begin
                mem_r[wr_ptr_r] <= wdata;
                wr_ptr_r        <= ptr_inc(wr_ptr_r);
            end
            if (pop) begin
                rd_ptr_r <= ptr_inc(rd_ptr_r);
            end
            count_r <= count_r + CNT_W'(push) - CNT_W'(pop);
        end
    end

    assign rdata = mem_r[rd_ptr_r];
    assign count = count_r;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: credit-limited AXI reads from CRAM, predecode
// redirects, mispredict flush and an instruction queue toward the core.
module fetch_unit import fcpu_pkg::*; #(
    parameter int ADDR_W          = CRAM_ADDR_W,
    parameter int QUEUE_DEPTH     = 4,
    parameter int MAX_OUTSTANDING = 4,
    parameter int PC_STEP         = 4
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              ce,
    input  logic              take_flag,
    input  logic              pred_miss,
    input  logic [ADDR_W-1:0] pred_miss_dst,
    output logic [3:0]        s_cram_arid,
    output logic [7:0]        s_cram_arlen,
    output logic [2:0]        s_cram_arsize,
    output logic [1:0]        s_cram_arburst,
    output logic              s_cram_arlock,
    output logic [3:0]        s_cram_arcache,
    output logic [2:0]        s_cram_arprot,
    output logic [3:0]        s_cram_arqos,
    output logic [31:0]       s_cram_araddr,
    output logic              s_cram_arvalid,
    input  logic              s_cram_arready,
    output logic              s_cram_rready,
    input  logic [3:0]        s_cram_rid,
    input  logic [31:0]       s_cram_rdata,
    input  logic [1:0]        s_cram_rresp,
    input  logic              s_cram_rlast,
    input  logic              s_cram_rvalid,
    output logic              o_valid,
    output logic [ADDR_W-1:0] o_current_pc,
    output logic [DATA_W-1:0] o_current_inst,
    output logic              o_err,
    output logic [ADDR_W-1:0] o_taken_pc,
    output logic [ADDR_W-1:0] o_untaken_pc
);
    localparam int CNT_W  = $clog2(MAX_OUTSTANDING) + 1;
    localparam int QCNT_W = $clog2(QUEUE_DEPTH) + 1;

    logic [ADDR_W-1:0] fetch_pc_r, fetch_pc_nxt_s, araddr_r, araddr_nxt_s;
    logic              arvalid_r, arvalid_nxt_s, stale_r, stale_nxt_s;
    logic [CNT_W-1:0]  outstanding_r, outstanding_nxt_s, drop_cnt_r, drop_cnt_nxt_s;
    logic [CNT_W-1:0]  pc_cnt_unused_s;
    logic [QCNT_W-1:0] q_count_s, occ_nxt_s;
    logic              ar_hs_s, holding_s, r_beat_s, beat_drop_s, beat_keep_s;
    logic              jmp_s, br_take_s, redirect_s, credit_s, q_pop_s, o_valid_s;
    logic [5:0]        opcode_s;
    logic [ADDR_W-1:0] pc_head_s, head_pc_s, head_tgt_s, head_seq_s;
    fetch_entry_t      q_wdata_s, q_head_s;
    logic              unused_s;

    assign s_cram_arid    = AXI_ARID;
    assign s_cram_arlen   = AXI_ARLEN;
    assign s_cram_arsize  = AXI_ARSIZE;
    assign s_cram_arburst = AXI_ARBURST;
    assign s_cram_arlock  = AXI_ARLOCK;
    assign s_cram_arcache = AXI_ARCACHE;
    assign s_cram_arprot  = AXI_ARPROT;
    assign s_cram_arqos   = AXI_ARQOS;
    assign s_cram_araddr  = 32'(araddr_r);
    assign s_cram_arvalid = arvalid_r;
    assign s_cram_rready  = nrst;

    assign ar_hs_s     = arvalid_r & s_cram_arready;
    assign holding_s   = arvalid_r & ~s_cram_arready;
    assign r_beat_s    = s_cram_rvalid & nrst;
    assign beat_drop_s = r_beat_s & (drop_cnt_r != '0);
    assign beat_keep_s = r_beat_s & (drop_cnt_r == '0) & ~pred_miss;
    assign opcode_s    = s_cram_rdata[31:26];
    assign jmp_s       = beat_keep_s & (opcode_s == I_JMP);
    assign br_take_s   = beat_keep_s & is_branch_op(opcode_s) & take_flag;
    assign redirect_s  = pred_miss | jmp_s | br_take_s;
    assign o_valid_s   = (q_count_s != '0);
    assign q_pop_s     = ce & o_valid_s & ~pred_miss;

    assign q_wdata_s = '{pc: 32'(pc_head_s), take_flag: take_flag,
                         is_branch: is_branch_op(opcode_s), err: |s_cram_rresp,
                         inst: s_cram_rdata};

    // PC tags follow every issued read, including ones that will be dropped
    fetch_fifo #(.WIDTH(ADDR_W), .DEPTH(MAX_OUTSTANDING), .CNT_W(CNT_W)) u_pc_fifo (
        .clk(clk), .nrst(nrst), .flush(1'b0),
        .push(ar_hs_s), .wdata(araddr_r), .pop(r_beat_s),
        .rdata(pc_head_s), .count(pc_cnt_unused_s)
    );

    fetch_fifo #(.WIDTH($bits(fetch_entry_t)), .DEPTH(QUEUE_DEPTH), .CNT_W(QCNT_W)) u_inst_q (
        .clk(clk), .nrst(nrst), .flush(pred_miss),
        .push(beat_keep_s), .wdata(q_wdata_s), .pop(q_pop_s),
        .rdata(q_head_s), .count(q_count_s)
    );

    // Next fetch PC, drop count and AR request decision
    always_comb begin
        outstanding_nxt_s = outstanding_r + CNT_W'(ar_hs_s) - CNT_W'(r_beat_s);
        if (pred_miss) begin
            occ_nxt_s = '0;
        end else begin
            occ_nxt_s = q_count_s + QCNT_W'(beat_keep_s) - QCNT_W'(q_pop_s);
        end
        credit_s = (int'(outstanding_nxt_s) + int'(occ_nxt_s) < QUEUE_DEPTH) &&
                   (int'(outstanding_nxt_s) < MAX_OUTSTANDING);

        if (pred_miss) begin
            fetch_pc_nxt_s = pred_miss_dst;
        end else if (jmp_s) begin
            fetch_pc_nxt_s = ADDR_W'(s_cram_rdata[21:0]);
        end else if (br_take_s) begin
            fetch_pc_nxt_s = ADDR_W'(s_cram_rdata[14:0]);
        end else if (ar_hs_s && !stale_r) begin
            fetch_pc_nxt_s = fetch_pc_r + ADDR_W'(PC_STEP);
        end else begin
            fetch_pc_nxt_s = fetch_pc_r;
        end

        // A request held across a redirect is stale and joins the drop count when it issues
        if (redirect_s) begin
            drop_cnt_nxt_s = outstanding_nxt_s;
        end else begin
            drop_cnt_nxt_s = drop_cnt_r - CNT_W'(beat_drop_s) + CNT_W'(ar_hs_s & stale_r);
        end

        stale_nxt_s   = holding_s & (stale_r | redirect_s);
        arvalid_nxt_s = holding_s | credit_s;
        if (holding_s) begin
            araddr_nxt_s = araddr_r;
        end else begin
            araddr_nxt_s = fetch_pc_nxt_s;
        end
    end

    // Fetch state registers
    always_ff @(posedge clk) begin
        if (!nrst) begin
            fetch_pc_r    <= '0;
            araddr_r      <= '0;
            arvalid_r     <= 1'b0;
            stale_r       <= 1'b0;
            outstanding_r <= '0;
            drop_cnt_r    <= '0;
        end else begin
            fetch_pc_r    <= fetch_pc_nxt_s;
            araddr_r      <= araddr_nxt_s;
            arvalid_r     <= arvalid_nxt_s;
            stale_r       <= stale_nxt_s;
            outstanding_r <= outstanding_nxt_s;
            drop_cnt_r    <= drop_cnt_nxt_s;
        end
    end

    assign head_pc_s  = ADDR_W'(q_head_s.pc);
    assign head_tgt_s = ADDR_W'(q_head_s.inst[14:0]);
    assign head_seq_s = head_pc_s + ADDR_W'(PC_STEP);

    // Head presentation; everything reads zero while the queue is empty
    always_comb begin
        o_valid        = o_valid_s;
        o_current_pc   = '0;
        o_current_inst = '0;
        o_err          = 1'b0;
        o_taken_pc     = '0;
        o_untaken_pc   = '0;
        if (o_valid_s) begin
            o_current_pc   = head_pc_s;
            o_current_inst = q_head_s.inst;
            o_err          = q_head_s.err;
            if (q_head_s.is_branch && q_head_s.take_flag) begin
                o_taken_pc   = head_tgt_s;
                o_untaken_pc = head_seq_s;
            end else if (q_head_s.is_branch) begin
                o_taken_pc   = head_seq_s;
                o_untaken_pc = head_tgt_s;
            end else begin
                o_taken_pc   = '0;
                o_untaken_pc = '0;
            end
        end else begin
            o_valid = 1'b0;
        end
    end

    assign unused_s = ^{s_cram_rid, s_cram_rlast, q_head_s.pc, pc_cnt_unused_s};

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with an in-order single-cycle CRAM responder.
module tb_fetch_unit;
    import fcpu_pkg::*;

    logic        clk, nrst, ce, take_flag, pred_miss;
    logic [15:0] pred_miss_dst;
    logic [3:0]  arid, arcache, arqos, rid;
    logic [7:0]  arlen;
    logic [2:0]  arsize, arprot;
    logic [1:0]  arburst, rresp;
    logic        arlock, arvalid, arready, rready, rlast, rvalid;
    logic [31:0] araddr, rdata;
    logic        o_valid, o_err;
    logic [15:0] o_current_pc, o_taken_pc, o_untaken_pc;
    logic [31:0] o_current_inst;

    int          n_cmp = 0;
    int          n_err = 0;
    logic        rsp_en;
    logic [31:0] rsp_q [$];
    logic [31:0] imem [logic [31:0]];
    bit          errmap [logic [31:0]];

    fetch_unit dut (
        .clk(clk), .nrst(nrst), .ce(ce), .take_flag(take_flag),
        .pred_miss(pred_miss), .pred_miss_dst(pred_miss_dst),
        .s_cram_arid(arid), .s_cram_arlen(arlen), .s_cram_arsize(arsize),
        .s_cram_arburst(arburst), .s_cram_arlock(arlock), .s_cram_arcache(arcache),
        .s_cram_arprot(arprot), .s_cram_arqos(arqos), .s_cram_araddr(araddr),
        .s_cram_arvalid(arvalid), .s_cram_arready(arready), .s_cram_rready(rready),
        .s_cram_rid(rid), .s_cram_rdata(rdata), .s_cram_rresp(rresp),
        .s_cram_rlast(rlast), .s_cram_rvalid(rvalid),
        .o_valid(o_valid), .o_current_pc(o_current_pc), .o_current_inst(o_current_inst),
        .o_err(o_err), .o_taken_pc(o_taken_pc), .o_untaken_pc(o_untaken_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] inst_at(input logic [31:0] a);
        if (imem.exists(a)) return imem[a];
        else return 32'hF000_0000 | a;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: record the AR handshake, clock, then present the next R beat
    task automatic step();
        logic [31:0] a;
        if (nrst && arvalid && arready) rsp_q.push_back(araddr);
        @(posedge clk);
        #1;
        if (!nrst) begin
            rsp_q.delete();
            rvalid = 1'b0; rdata = 32'd0; rresp = 2'd0;
        end else if (rsp_en && rsp_q.size() > 0) begin
            a = rsp_q.pop_front();
            rvalid = 1'b1;
            rdata  = inst_at(a);
            rresp  = errmap.exists(a) ? 2'd2 : 2'd0;
        end else begin
            rvalid = 1'b0; rdata = 32'd0; rresp = 2'd0;
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        nrst = 1'b0; ce = 1'b0; pred_miss = 1'b0; take_flag = 1'b0;
        arready = 1'b1; rsp_en = 1'b1;
        step(); step();
        imem.delete(); errmap.delete();
    endtask

    initial begin
        nrst = 1'b0; ce = 1'b0; take_flag = 1'b0; pred_miss = 1'b0;
        pred_miss_dst = 16'h0; arready = 1'b1; rsp_en = 1'b1;
        rid = 4'd0; rlast = 1'b1; rvalid = 1'b0; rdata = 32'd0; rresp = 2'd0;

        // Reset state and constant AR attributes
        step(); step();
        chk("rst_arvalid", {31'd0, arvalid}, 32'd0);
        chk("rst_araddr", araddr, 32'd0);
        chk("rst_o_valid", {31'd0, o_valid}, 32'd0);
        chk("rst_pc", {16'd0, o_current_pc}, 32'd0);
        chk("rst_inst", o_current_inst, 32'd0);
        chk("rst_taken", {16'd0, o_taken_pc}, 32'd0);
        chk("rst_untaken", {16'd0, o_untaken_pc}, 32'd0);
        chk("rst_rready", {31'd0, rready}, 32'd0);
        chk("ar_size_burst", {27'd0, arsize, arburst}, 32'h9);

        // Sequential fetch to credit exhaustion; BLT not taken at 4 with rresp error
        imem[32'h4] = 32'h4800_0024;
        errmap[32'h4] = 1'b1;
        nrst = 1'b1;
        step(); chk("t1_arvalid_first", {31'd0, arvalid}, 32'd1);
        chk("t1_araddr0", araddr, 32'h0);
        chk("t1_rready", {31'd0, rready}, 32'd1);
        step(); chk("t1_araddr4", araddr, 32'h4);
        step(); chk("t1_araddr8", araddr, 32'h8);
        chk("t1_valid", {31'd0, o_valid}, 32'd1);
        chk("t1_head_pc0", {16'd0, o_current_pc}, 32'h0);
        chk("t1_err0", {31'd0, o_err}, 32'd0);
        step(); chk("t1_araddr12", araddr, 32'hC);
        step(); chk("t1_credit_out", {31'd0, arvalid}, 32'd0);
        step(); step();
        chk("t1_credit_hold", {31'd0, arvalid}, 32'd0);
        chk("t1_frozen_pc", {16'd0, o_current_pc}, 32'h0);
        chk("t1_inst0", o_current_inst, 32'hF000_0000);
        ce = 1'b1;
        step();
        chk("t1_pc4", {16'd0, o_current_pc}, 32'h4);
        chk("t1_err4", {31'd0, o_err}, 32'd1);
        chk("t1_nt_taken", {16'd0, o_taken_pc}, 32'h8);
        chk("t1_nt_untaken", {16'd0, o_untaken_pc}, 32'h24);
        chk("t1_resume_valid", {31'd0, arvalid}, 32'd1);
        chk("t1_resume_addr", araddr, 32'h10);
        step();
        ce = 1'b0;
        chk("t1_pc8", {16'd0, o_current_pc}, 32'h8);
        chk("t1_err8", {31'd0, o_err}, 32'd0);
        chk("t1_nb_taken", {16'd0, o_taken_pc}, 32'h0);

        // JMP to 0x100 returned with three reads still in flight
        do_reset();
        imem[32'h0] = 32'h0800_0100;
        rsp_en = 1'b0;
        nrst = 1'b1;
        repeat (5) step();
        chk("t2_max_out", {31'd0, arvalid}, 32'd0);
        rsp_en = 1'b1;
        step(); step();
        chk("t2_jmp_head", o_current_inst, 32'h0800_0100);
        chk("t2_jmp_noissue", {31'd0, arvalid}, 32'd0);
        step();
        chk("t2_new_addr", araddr, 32'h100);
        chk("t2_new_valid", {31'd0, arvalid}, 32'd1);
        step(); step();
        chk("t2_drops_hidden", {16'd0, o_current_pc}, 32'h0);
        step();
        ce = 1'b1;
        step(); chk("t2_pc100", {16'd0, o_current_pc}, 32'h100);
        step(); chk("t2_pc104", {16'd0, o_current_pc}, 32'h104);
        step(); chk("t2_pc108", {16'd0, o_current_pc}, 32'h108);
        ce = 1'b0;

        // Taken branch at pc 8 to 0x40
        do_reset();
        imem[32'h8] = 32'h5400_0040;
        take_flag = 1'b1;
        nrst = 1'b1;
        repeat (6) step();
        chk("t3_redir_valid", {31'd0, arvalid}, 32'd1);
        chk("t3_redir_addr", araddr, 32'h40);
        ce = 1'b1;
        step(); step();
        ce = 1'b0;
        chk("t3_br_pc", {16'd0, o_current_pc}, 32'h8);
        chk("t3_taken", {16'd0, o_taken_pc}, 32'h40);
        chk("t3_untaken", {16'd0, o_untaken_pc}, 32'hC);
        ce = 1'b1;
        step();
        ce = 1'b0;
        chk("t3_next_pc", {16'd0, o_current_pc}, 32'h40);
        take_flag = 1'b0;

        // Mispredict while an AR is pending, then mispredict colliding with ce
        do_reset();
        arready = 1'b0;
        nrst = 1'b1;
        step(); step();
        chk("t4_pend_valid", {31'd0, arvalid}, 32'd1);
        pred_miss = 1'b1; pred_miss_dst = 16'h200;
        step();
        pred_miss = 1'b0;
        chk("t4_hold_valid", {31'd0, arvalid}, 32'd1);
        chk("t4_hold_addr", araddr, 32'h0);
        chk("t4_flush_valid", {31'd0, o_valid}, 32'd0);
        arready = 1'b1;
        step(); chk("t4_new_addr", araddr, 32'h200);
        step(); chk("t4_dropped", {31'd0, o_valid}, 32'd0);
        step(); chk("t4_valid", {31'd0, o_valid}, 32'd1);
        chk("t4_pc200", {16'd0, o_current_pc}, 32'h200);
        pred_miss = 1'b1; pred_miss_dst = 16'h300; ce = 1'b1;
        step();
        pred_miss = 1'b0; ce = 1'b0;
        chk("t4_flush_wins", {31'd0, o_valid}, 32'd0);
        chk("t4_addr300", araddr, 32'h300);
        step(); chk("t4_drop2", {31'd0, o_valid}, 32'd0);
        step(); chk("t4_pc300", {16'd0, o_current_pc}, 32'h300);

        // Reset with two reads outstanding
        do_reset();
        rsp_en = 1'b0;
        nrst = 1'b1;
        repeat (3) step();
        chk("t6_pre_valid", {31'd0, arvalid}, 32'd1);
        nrst = 1'b0;
        step();
        chk("t6_arvalid", {31'd0, arvalid}, 32'd0);
        chk("t6_araddr", araddr, 32'h0);
        chk("t6_o_valid", {31'd0, o_valid}, 32'd0);
        chk("t6_inst", o_current_inst, 32'd0);
        nrst = 1'b1; rsp_en = 1'b1;
        step();
        chk("t6_restart_valid", {31'd0, arvalid}, 32'd1);
        chk("t6_restart_addr", araddr, 32'h0);
        step(); step();
        chk("t6_head_valid", {31'd0, o_valid}, 32'd1);
        chk("t6_head_pc", {16'd0, o_current_pc}, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch front end between the CRAM AXI read port and the core; the next generation of the single-slot scheduler. It keeps up to MAX_OUTSTANDING AXI reads in flight and buffers returned instructions in a flushable queue. It predecodes jumps and branches to redirect fetch, and squashes in-flight reads on a core mispredict. A strict AR/R valid-ready handshake replaces the free-running request stream.

## Interface
- ADDR_W, CRAM_ADDR_W: PC width in bits.
- QUEUE_DEPTH, 4: instruction queue entries; power of 2, ≥2.
- MAX_OUTSTANDING, 4: maximum issued-but-unreturned AR requests; ≤ QUEUE_DEPTH.
- PC_STEP, 4: sequential PC increment.
- clk  in  1  clock
- nrst  in  1  reset; one clock, synchronous, active-low
- ce  in  1  core advance; the head is consumed when ce=1 and o_valid=1
- take_flag  in  1  predictor decision, sampled in the cycle a branch response is accepted
- pred_miss  in  1  core mispredict, one-cycle pulse
- pred_miss_dst  in  ADDR_W  restart PC
- s_cram_ar{id,len,size,burst,lock,cache,prot,qos}  out  4/8/3/2/1/4/3/4  constants 0/0/2/1/0/0/0/0
- s_cram_araddr  out  32  fetch address, zero-extended PC
- s_cram_arvalid  out  1;  s_cram_arready  in  1
- s_cram_rready  out  1  equals nrst
- s_cram_rid  in  4;  s_cram_rdata  in  32;  s_cram_rresp  in  2;  s_cram_rlast  in  1;  s_cram_rvalid  in  1
- o_valid  out  1  queue head valid
- o_current_pc  out  ADDR_W;  o_current_inst  out  DATA_W;  o_err  out  1  head rresp≠0
- o_taken_pc, o_untaken_pc  out  ADDR_W  head branch targets

## Operation
- State: fetch_pc, outstanding counter, drop_cnt, and a queue whose entries hold {pc, take_flag, is_branch, err, inst}.
- Credit: arvalid=1 when outstanding + occupancy < QUEUE_DEPTH and outstanding < MAX_OUTSTANDING. An R beat therefore always has space, and rready is held at 1.
- AR handshake: once arvalid=1, araddr is held until arready, even across redirects. A request issued before a redirect is dropped on return. On the handshake, fetch_pc += PC_STEP and outstanding++.
- R beat with drop_cnt>0: discarded, drop_cnt--, outstanding--. Otherwise it is enqueued with pc = head of an internal in-order PC FIFO that has MAX_OUTSTANDING entries.
- Predecode of an accepted beat:
  - opcode I_JMP: fetch_pc ← rdata[21:0].
  - branch opcode (I_BLE, I_BLEI, I_BLT, I_BLTF, I_BLTI, I_BEQ, I_BEQF, I_BEQI) with take_flag=1: fetch_pc ← rdata[14:0].
  - On either redirect, drop_cnt ← outstanding after this cycle's issue and return.
- pred_miss: the queue is flushed and fetch_pc ← pred_miss_dst. drop_cnt ← outstanding after this cycle's issue, including the beat returning this cycle, which is not enqueued. pred_miss takes priority over a predecode redirect in the same cycle.
- Head outputs when is_branch: take_flag=1 gives taken = inst[14:0], untaken = pc+PC_STEP; take_flag=0 swaps them. Non-branch heads drive 0. With o_valid=0 all o_* outputs are 0.
- Widths: PC arithmetic is modulo 2^ADDR_W. Targets are zero-extended or truncated to ADDR_W.

## Timing
- Reset (nrst=0 at an edge): fetch_pc, outstanding, drop_cnt and the queue are cleared. arvalid=0, o_valid=0, all o_* = 0. Reset during outstanding reads abandons them; the interconnect is reset with the block.
- First arvalid rises the cycle after nrst goes high.
- Latency: AR handshake in cycle N, R beat in cycle ≥N+1, o_valid in the cycle after the beat.
- The queue dequeues and enqueues in the same cycle; a full queue plus an R beat cannot occur because of the credit rule.
- ce=0 freezes the queue head. Fetch continues until credit runs out.
- pred_miss in cycle N: o_valid=0 in N+1. The first new-path AR goes out in N+1, or after the pending AR completes.
- Simultaneous pred_miss and ce consume: the flush wins.

## Structure
- The following go in fcpu_pkg: the opcode constants, is_branch_op(), a fetch_entry_t typedef, and an AXI constant localparam block.
- Sub-module fetch_fifo: parametrised synchronous FIFO with a flush input, used for both the instruction queue and the PC FIFO.

## Test plan
- Reset release with arready=1 and a 1-cycle R responder: araddr = 0,4,8,12. After 4 requests arvalid stays low until ce consumes. The head shows pc=0.
- I_JMP to 0x100 returned while 3 reads are in flight: 3 beats are dropped, the next enqueued pc is 0x100, and the queue contents stay contiguous.
- Branch with take_flag=1 and target 0x40 at pc=8: fetch resumes at 0x40, o_taken_pc=0x40, o_untaken_pc=0xC.
- pred_miss with dst 0x200 while arvalid is pending and unaccepted: araddr holds the old value until arready, that beat is dropped, o_valid=0 next cycle, and the next pc is 0x200.
- rresp=2 on one beat: that entry has o_err=1 and the others have o_err=0.
- nrst low mid-stream with 2 outstanding: all outputs are 0 the next cycle, and after release fetch restarts at 0.
